// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between fetch_unit (master) and instruction memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage feeding the BittyPro control unit: PC register, req/ack memory fetch, held instruction.
// Define FETCH_BRANCH_EN to honour branch_taken/branch_target on done; otherwise PC always steps by one.
module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      memBus,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_done,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_nextPc;
  logic [ADDR_W-1:0] w_advancePc;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_nextInst;

`ifdef FETCH_BRANCH_EN
  assign w_advancePc = i_branch_taken ? i_branch_target : r_pc + ADDR_W'(1);
`else
  // Branch ports stay on the boundary but feed nothing; this sink only keeps them visibly consumed.
  logic w_unusedBranch;
  assign w_unusedBranch = ^{i_branch_taken, i_branch_target};
  assign w_advancePc    = r_pc + ADDR_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= START;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_inst  <= w_nextInst;
    end
  end

  // done, halt and branch inputs only matter in HOLD; a stray ack outside FETCH is dropped.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextInst  = r_inst;
    case (r_state)
      START: w_nextState = FETCH;
      FETCH: begin
        if (memBus.mem_ack) begin
          w_nextInst  = memBus.mem_rdata;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (i_done) begin
          w_nextPc    = w_advancePc;
          w_nextState = i_halt ? HALTED : FETCH;
        end
      end
      HALTED:  w_nextState = HALTED;
      default: w_nextState = START;
    endcase
  end

  assign memBus.mem_req  = (r_state == FETCH);
  assign memBus.mem_addr = r_pc;
  assign o_inst          = r_inst;
  assign o_inst_valid    = (r_state == HOLD);
  assign o_halted        = (r_state == HALTED);
  assign o_pc            = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset latency, sequential/wrapping PC, wait states,
// branch redirect, halt, reset during fetch and ignored done pulses.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] inst;
  logic        instValid;
  logic        done;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic        halt;
  logic [7:0]  pc;
  logic        halted;
  logic        ack;

  logic [15:0] memory [256];
  logic [7:0]  expPc;
  int          testsRun;
  int          testsFailed;

  fetch_unit_if #(.ADDR_W(8), .INST_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .reset           (reset),
    .memBus          (bus.master),
    .o_inst          (inst),
    .o_inst_valid    (instValid),
    .i_done          (done),
    .i_branch_taken  (branchTaken),
    .i_branch_target (branchTarget),
    .i_halt          (halt),
    .o_pc            (pc),
    .o_halted        (halted)
  );

  assign bus.mem_ack   = ack;
  assign bus.mem_rdata = memory[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word 0 fixed, the rest a simple address-derived pattern.
  function automatic logic [15:0] memWord(input logic [7:0] a);
    if (a == 8'h00) return 16'h2A04;
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic bt, input logic [7:0] tgt,
                               input logic h, input logic a);
    done         = d;
    branchTaken  = bt;
    branchTarget = tgt;
    halt         = h;
    ack          = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleAfterReset();
    checkOutput("rst_mem_req",    32'(bus.mem_req),  32'd0);
    checkOutput("rst_inst_valid", 32'(instValid),    32'd0);
    checkOutput("rst_halted",     32'(halted),       32'd0);
    checkOutput("rst_pc",         32'(pc),           32'h00);
    checkOutput("rst_mem_addr",   32'(bus.mem_addr), 32'h00);
    checkOutput("rst_inst",       32'(inst),         32'h0000);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < 256; i++) memory[i] = memWord(8'(i));

    // Reset, then two edges to the first held instruction.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkIdleAfterReset();
    reset = 1'b0;
    tick();
    checkOutput("t1_req_edge1",   32'(bus.mem_req), 32'd1);
    checkOutput("t1_valid_edge1", 32'(instValid),   32'd0);
    tick();
    checkOutput("t1_valid_edge2", 32'(instValid),   32'd1);
    checkOutput("t1_inst",        32'(inst),        32'h2A04);
    checkOutput("t1_pc",          32'(pc),          32'h00);
    checkOutput("t1_req_dropped", 32'(bus.mem_req), 32'd0);

    // Sequential advance.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t2_pc",       32'(pc),           32'h01);
    checkOutput("t2_mem_addr", 32'(bus.mem_addr), 32'h01);
    checkOutput("t2_mem_req",  32'(bus.mem_req),  32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t2_inst", 32'(inst), 32'(memWord(8'h01)));

    // Three wait cycles: request held four cycles at a stable address.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("t3_req_c%0d", c),   32'(bus.mem_req),  32'd1);
      checkOutput($sformatf("t3_addr_c%0d", c),  32'(bus.mem_addr), 32'h02);
      checkOutput($sformatf("t3_valid_c%0d", c), 32'(instValid),    32'd0);
      if (c == 3) ack = 1'b1;
      tick();
    end
    checkOutput("t3_valid_after_ack", 32'(instValid), 32'd1);
    checkOutput("t3_inst",            32'(inst),      32'(memWord(8'h02)));

    // Branch request: redirect when the feature is built in, plain increment otherwise.
`ifdef FETCH_BRANCH_EN
    expPc = 8'h40;
`else
    expPc = 8'h03;
`endif
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b0, 1'b1);
    tick();
    checkOutput("t4_pc",       32'(pc),           32'(expPc));
    checkOutput("t4_mem_addr", 32'(bus.mem_addr), 32'(expPc));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t4_inst", 32'(inst), 32'(memWord(expPc)));

    // Fresh start, then done pulsed while still fetching must be ignored.
    reset = 1'b1;
    tick();
    checkIdleAfterReset();
    reset = 1'b0;
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("t6_fetch_pc", 32'(pc), 32'h01);
    tick();
    checkOutput("t6_done_in_fetch_pc",  32'(pc),          32'h01);
    checkOutput("t6_done_in_fetch_req", 32'(bus.mem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t6_fetch_resumed", 32'(instValid), 32'd1);

    // Walk to pc=5, then halt on done.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      tick();
    end
    checkOutput("t5_pc_before", 32'(pc), 32'h05);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("t5_halted", 32'(halted), 32'd1);
    checkOutput("t5_pc",     32'(pc),     32'h06);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c[0], 1'b1, 8'h40, c[1], c[2]);
      checkOutput($sformatf("t5_req_c%0d", c), 32'(bus.mem_req), 32'd0);
      checkOutput($sformatf("t5_pc_c%0d", c),  32'(pc),          32'h06);
      tick();
    end
    checkOutput("t5_still_halted", 32'(halted), 32'd1);

    // Reset recovers from halt and refetches word 0.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    checkIdleAfterReset();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("t5_restart_inst", 32'(inst), 32'h2A04);
    checkOutput("t5_restart_pc",   32'(pc),   32'h00);

    // Run sequentially up to 0xFF, then wrap to 0.
    for (int k = 0; k < 255; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      tick();
    end
    checkOutput("t2_pc_ff",   32'(pc),   32'hFF);
    checkOutput("t2_inst_ff", 32'(inst), 32'(memWord(8'hFF)));
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t2_wrap_pc",   32'(pc),           32'h00);
    checkOutput("t2_wrap_addr", 32'(bus.mem_addr), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("t2_wrap_inst", 32'(inst), 32'h2A04);

    // Reset during a stalled fetch; a late ack in START is dropped.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("t6_stalled_req", 32'(bus.mem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkIdleAfterReset();
    reset = 1'b0;
    ack   = 1'b1;
    tick();
    checkOutput("t6_late_ack_inst", 32'(inst),         32'h0000);
    checkOutput("t6_refetch_addr",  32'(bus.mem_addr), 32'h00);
    checkOutput("t6_refetch_req",   32'(bus.mem_req),  32'd1);
    tick();
    checkOutput("t6_refetch_inst",  32'(inst),         32'h2A04);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the BittyPro control unit.
- Holds the program counter and requests one 16-bit instruction word from instruction memory through a req/ack handshake.
- Presents the word on `inst`, held stable, for the control unit's 4-state execute sequence.
- Advances the PC (sequential or branch) only when the control unit pulses `done`.

Parameters:
- ADDR_W, 8, width of PC and memory address; PC wraps modulo 2^ADDR_W.
- INST_W, 16, instruction word width; must be 16 for the control unit field layout.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  ADDR_W  fetch address; equals pc while mem_req=1.
- mem_ack  input  1  memory response valid; mem_rdata is valid in the same cycle.
- mem_rdata  input  INST_W  instruction word from memory.
- inst  output  INST_W  instruction presented to the control unit.
- inst_valid  output  1  inst holds a fetched word awaiting execution.
- done  input  1  control unit has finished executing inst (1-cycle pulse).
- branch_taken  input  1  redirect the PC on this done.
- branch_target  input  ADDR_W  redirect target.
- halt  input  1  stop fetching after the current instruction completes.
- pc  output  ADDR_W  current program counter.
- halted  output  1  fetch stopped.

Behaviour:

Reset values (after a clock edge with reset=1):
- state=START, pc=RESET_PC, inst=0.
- inst_valid=0, mem_req=0, mem_addr=RESET_PC, halted=0.

Decoded outputs (combinational functions of registered state only):
- mem_req = (state==FETCH).
- inst_valid = (state==HOLD).
- halted = (state==HALTED).
- mem_addr = pc at all times.

States and transitions:
- START: no outputs asserted. Go to FETCH unconditionally next cycle; any mem_ack here is ignored.
- FETCH: mem_req=1.
  - mem_ack=1: capture inst<=mem_rdata and go to HOLD.
  - mem_ack=0: stay in FETCH with mem_req held high and mem_addr stable. There is no timeout.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
- HOLD: inst and pc stay frozen until done=1.
  - On done: pc<=branch_taken ? branch_target : pc+1 (ADDR_W-bit wrap, so all-ones+1 gives 0).
  - If halt=1 in the same cycle: go to HALTED. Otherwise go to FETCH.
  - inst keeps its old value until the next ack.
- HALTED: mem_req=0; pc holds the updated value. Exit only via reset; done, ack and branch inputs are ignored.

Input sampling rules:
- done is honoured only in HOLD; done in START/FETCH/HALTED is ignored.
- branch_taken/branch_target are sampled only in the HOLD cycle where done=1.
- halt is sampled only with done in HOLD; halt without done has no effect.

Latency:
- With mem_ack tied high, inst_valid rises on the 2nd rising edge after reset deasserts.
- Minimum issue interval is done-to-inst_valid = 1 FETCH cycle plus the memory wait cycles.

Reset mid-fetch:
- The request is abandoned; mem_req drops at the reset edge.
- A late ack arriving in START is ignored, and the refetch starts from RESET_PC.

Optional Feature:
- Macro FETCH_BRANCH_EN.
- When defined: branch redirect behaves as specified above.
- When undefined:
  - branch_taken and branch_target ports remain present but are ignored.
  - The PC always advances by pc+1 on done.
  - No branch-related logic is synthesized.

Test Plan:
1. Reset with RESET_PC=0, mem_ack tied 1, memory[0]=16'h2A04 → pc=0 and inst_valid=1 two cycles after reset release; inst=16'h2A04; mem_req high for exactly 1 cycle.
2. Done pulse in HOLD, no branch → pc=1, mem_addr=1, mem_req=1 the next cycle, inst=memory[1] one cycle later. Repeat with pc=8'hFF → pc wraps to 0.
3. mem_ack held low 3 cycles in FETCH → mem_req stays 1 for 4 cycles with mem_addr stable; inst_valid=0 until the ack cycle's edge.
4. FETCH_BRANCH_EN defined, done with branch_taken=1, branch_target=8'h40 → pc=8'h40, next mem_addr=8'h40. Same stimulus with the macro undefined → pc=old pc+1.
5. Done with halt=1 at pc=5 → halted=1, pc=6, mem_req stays 0 for 10 cycles; later done/ack pulses cause no change. Then reset → normal fetch from 0.
6. Reset asserted while in FETCH with mem_ack=0, ack=1 arriving in the START cycle → inst stays 0 and the fetch restarts at RESET_PC. Separately, done pulsed while in FETCH → ignored, pc unchanged.
